// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: DX latch, load-use stall, branch flush and multdiv sequencing.
// Optional build macro MD_TIMEOUT_EN adds a BUSY watchdog that force-releases after MD_TIMEOUT cycles.
//
// state | meaning
// IDLE  | no multdiv in flight; a mul/div in dx_ir starts one
// BUSY  | multdiv running; pipeline held until md_ready (or watchdog)
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] fd_pc,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic [31:0] dx_ir,
  output logic [31:0] dx_pc,
  output logic        stall_fd,
  output logic        flush_fd,
  output logic        xm_bubble,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_busy,
  output logic        md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t state, state_nxt;

  logic [4:0] dx_op;
  logic [4:0] dx_alu;
  logic [4:0] dx_rd;
  logic       dx_is_mul;
  logic       dx_is_div;
  logic       dx_is_lw;

  logic [4:0] fd_op;
  logic [4:0] fd_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic       fd_uses_rs;
  logic       fd_uses_rt;
  logic       fd_uses_rd;

  logic       start_any;
  logic       timeout_hit;
  logic       release_md;
  logic       md_hold;
  logic       load_use;

  // ---------------------------------------------------------------- decode
  assign dx_op     = dx_ir[31:27];
  assign dx_rd     = dx_ir[26:22];
  assign dx_alu    = dx_ir[6:2];
  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign dx_is_lw  = (dx_op == OP_LW);

  assign fd_op = fd_ir[31:27];
  assign fd_rd = fd_ir[26:22];
  assign fd_rs = fd_ir[21:17];
  assign fd_rt = fd_ir[16:12];

  // sw data register (fd_rd of a sw) is deliberately absent: WM bypass forwards it.
  assign fd_uses_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                      (fd_op == OP_SW)    || (fd_op == OP_BNE)  || (fd_op == OP_BLT);
  assign fd_uses_rt = (fd_op == OP_RTYPE);
  assign fd_uses_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) ||
                     (fd_uses_rt && (fd_rt == dx_rd)) ||
                     (fd_uses_rd && (fd_rd == dx_rd)));

  // ---------------------------------------------------------------- multdiv control
  assign md_start_mult = (state == IDLE) && dx_is_mul;
  assign md_start_div  = (state == IDLE) && dx_is_div;
  assign start_any     = md_start_mult || md_start_div;
  assign md_busy       = (state == BUSY);

`ifdef MD_TIMEOUT_EN
  localparam logic [5:0] TO_LAST = 6'(MD_TIMEOUT - 1);

  logic [5:0] to_cnt;

  // Counter value is (BUSY cycle index - 1), so the MD_TIMEOUT-th cycle matches TO_LAST.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= 6'd0;
    end else if (start_any) begin
      to_cnt <= 6'd0;
    end else if ((state == BUSY) && !md_ready) begin
      to_cnt <= to_cnt + 6'd1;
    end
  end

  assign timeout_hit = (state == BUSY) && !md_ready && (to_cnt == TO_LAST);
`else
  logic [5:0] unused_md_timeout_cfg;
  assign unused_md_timeout_cfg = 6'(MD_TIMEOUT);
  assign timeout_hit = 1'b0;
`endif

  assign release_md = (state == BUSY) && (md_ready || timeout_hit);
  assign md_hold    = start_any || ((state == BUSY) && !release_md);
  // A reset landing mid-BUSY aborts silently rather than reporting a timeout.
  assign md_timeout = timeout_hit && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_any) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (release_md) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- pipeline control
  assign stall_fd  = load_use || md_hold;
  assign xm_bubble = md_hold;
  assign flush_fd  = branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      dx_ir <= 32'd0;
      dx_pc <= 32'd0;
    end else if (md_hold) begin
      dx_ir <= dx_ir;
      dx_pc <= dx_pc;
    end else if (branch_taken || load_use) begin
      dx_ir <= 32'd0;
      dx_pc <= 32'd0;
    end else begin
      dx_ir <= fd_ir;
      dx_pc <= fd_pc;
    end
  end

endmodule
